// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and alignment helper
// Used by mem_access_unit and load_align.
package mem_pkg;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    WAIT0 = 3'd2,
    BEAT1 = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_e;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    logic bad;
    case (sz)
      SZ_HALF:  bad = a[0];
      SZ_WORD:  bad = (a[1:0] != 2'b00);
      SZ_DWORD: bad = (a != 3'b000);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane extraction and sign/zero extension
// raw holds {beat1, beat0}; only dword loads use the upper half.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     raw,
  input  logic [2:0]      size_type,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sgn;

  always_comb begin
    sgn       = size_type[2];
    byte_lane = raw[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? raw[31:16] : raw[15:0];
    data      = '0;
    case (size_type[1:0])
      SZ_BYTE: begin
        data       = {XLEN{sgn & byte_lane[7]}};
        data[7:0]  = byte_lane;
      end
      SZ_HALF: begin
        data       = {XLEN{sgn & half_lane[15]}};
        data[15:0] = half_lane;
      end
      SZ_WORD: begin
        data       = {XLEN{sgn & raw[31]}};
        data[31:0] = raw[31:0];
      end
      default: data = XLEN'(raw);
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - core load/store sequencer onto a 32-bit beat bus
// Define MEM_DWORD_EN for two-beat dword accesses; otherwise dword requests are rejected as misaligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             Mem_rw,
  input  logic [2:0]       size_type,
  input  logic [31:0]      addr,
  input  logic [XLEN-1:0]  wdata,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rdata,
  output logic             misalign_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_be,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [BUS_W-1:0] bus_rdata
);

  state_e          state_q, state_d;
  logic            rw_q, rw_d;
  logic [2:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            req_bad;
  logic            in_beat;
  logic [31:0]     lane;
  logic [63:0]     ld_raw;
  logic [XLEN-1:0] ld_data;

`ifdef MEM_DWORD_EN
  logic [31:0]     lo_q, lo_d;
  logic            dword_q;
  assign dword_q = (size_q[1:0] == SZ_DWORD);
`else
  logic            unused_wdata_hi;
  assign unused_wdata_hi = ^wdata_q[XLEN-1:32];
`endif

  always_comb begin
    req_bad = misaligned(size_type[1:0], addr[2:0]);
`ifndef MEM_DWORD_EN
    if (size_type[1:0] == SZ_DWORD) req_bad = 1'b1;
`endif
  end

  always_comb begin
    ld_raw = {32'h0, bus_rdata[31:0]};
`ifdef MEM_DWORD_EN
    if (state_q == WAIT1) ld_raw = {bus_rdata[31:0], lo_q};
`endif
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw       (ld_raw),
    .size_type (size_q),
    .offset    (addr_q[1:0]),
    .data      (ld_data)
  );

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef MEM_DWORD_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d    = Mem_rw;
          size_d  = size_type;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = RESP;
            rdata_d = '0;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (bus_gnt) begin
          if (!rw_q) begin
            state_d = WAIT0;
          end else begin
            state_d = RESP;
            rdata_d = '0;
          end
`ifdef MEM_DWORD_EN
          if (rw_q && dword_q) begin
            state_d = BEAT1;
            rdata_d = rdata_q;
          end
`endif
        end
      end
      // Same-cycle rvalid in BEAT0 is not looked at; data is only taken here.
      WAIT0: begin
        if (bus_rvalid) begin
`ifdef MEM_DWORD_EN
          lo_d = bus_rdata[31:0];
          if (dword_q) begin
            state_d = BEAT1;
          end else begin
            state_d = RESP;
            rdata_d = ld_data;
          end
`else
          state_d = RESP;
          rdata_d = ld_data;
`endif
        end
      end
`ifdef MEM_DWORD_EN
      BEAT1: begin
        if (bus_gnt) begin
          if (rw_q) begin
            state_d = RESP;
            rdata_d = '0;
          end else begin
            state_d = WAIT1;
          end
        end
      end
      WAIT1: begin
        if (bus_rvalid) begin
          state_d = RESP;
          rdata_d = ld_data;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef MEM_DWORD_EN
    in_beat = (state_q == BEAT0) || (state_q == BEAT1);
`else
    in_beat = (state_q == BEAT0);
`endif
    case (size_q[1:0])
      SZ_BYTE: lane = {4{wdata_q[7:0]}};
      SZ_HALF: lane = {2{wdata_q[15:0]}};
      default: lane = wdata_q[31:0];
    endcase
`ifdef MEM_DWORD_EN
    if (state_q == BEAT1) lane = wdata_q[63:32];
`endif
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'h0;
    bus_wdata = '0;
    if (in_beat) begin
      bus_req   = 1'b1;
      bus_we    = rw_q;
      bus_addr  = {addr_q[31:2], 2'b00};
`ifdef MEM_DWORD_EN
      if (state_q == BEAT1) bus_addr = {addr_q[31:2], 2'b00} + 32'd4;
`endif
      case (size_q[1:0])
        SZ_BYTE: bus_be = 4'b0001 << addr_q[1:0];
        SZ_HALF: bus_be = 4'b0011 << addr_q[1:0];
        default: bus_be = 4'hF;
      endcase
      bus_wdata = BUS_W'(lane);
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign misalign_err = (state_q == RESP) && err_q;
  assign rdata        = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_DWORD_EN
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef MEM_DWORD_EN
      lo_q    <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - vector table plus scoreboard bench for mem_access_unit
// Expects dword two-beat behaviour only when MEM_DWORD_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        Mem_rw;
  logic [2:0]  size_type;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        rsp_valid;
  logic [63:0] rdata;
  logic        misalign_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  mem_access_unit #(.XLEN(64), .BUS_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .Mem_rw       (Mem_rw),
    .size_type    (size_type),
    .addr         (addr),
    .wdata        (wdata),
    .rsp_valid    (rsp_valid),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [63:0] wd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          nbeats;
    int          gdly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd0;
    logic [31:0] e_wd1;
    logic [63:0] e_rdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   rsp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual=1 required=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rdata, e.rdata);
        chk("rsp_err", {63'b0, misalign_err}, {63'b0, e.err});
      end
    end
  end

  task automatic add_vec(input logic rw, input logic [2:0] sz, input logic [31:0] a,
                         input logic [63:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                         input int nb, input int gd, input logic [31:0] ea, input logic [3:0] ebe,
                         input logic [31:0] ew0, input logic [31:0] ew1,
                         input logic [63:0] er, input logic ee);
    vec_t v;
    v.rw = rw; v.sz = sz; v.a = a; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
    v.nbeats = nb; v.gdly = gd; v.e_addr = ea; v.e_be = ebe;
    v.e_wd0 = ew0; v.e_wd1 = ew1; v.e_rdata = er; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic wait_rsp(input int c0, input int limit, output int waited);
    waited = -1;
    for (int w = 0; w < limit; w++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt != c0) begin
        waited = w;
        break;
      end
    end
    if (waited < 0) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   c0;
    int   waited;
    chk("ready_idle", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; Mem_rw = v.rw; size_type = v.sz; addr = v.a; wdata = v.wd;
    e.rdata = v.e_rdata; e.err = v.e_err;
    exp_q.push_back(e);
    c0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; Mem_rw = ~v.rw; size_type = 3'($urandom);
    addr = $urandom; wdata = {$urandom, $urandom};
    if (v.nbeats == 0) chk("mis_noreq", {63'b0, bus_req}, 64'd0);
    for (int b = 0; b < v.nbeats; b++) begin
      for (int k = 0; k <= v.gdly; k++) begin
        @(negedge clk);
        chk("beat_req", {63'b0, bus_req}, 64'd1);
        chk("beat_ready", {63'b0, req_ready}, 64'd0);
        chk("beat_addr", {32'b0, bus_addr}, {32'b0, v.e_addr + 32'(4 * b)});
        chk("beat_be", {60'b0, bus_be}, {60'b0, v.e_be});
        chk("beat_we", {63'b0, bus_we}, {63'b0, v.rw});
        if (v.rw) chk("beat_wdata", {32'b0, bus_wdata}, {32'b0, (b == 0) ? v.e_wd0 : v.e_wd1});
        if (k == v.gdly) bus_gnt = 1'b1;
      end
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      if (!v.rw) begin
        @(negedge clk);
        chk("wait_noreq", {63'b0, bus_req}, 64'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = (b == 0) ? v.rd0 : v.rd1;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
      end
    end
    wait_rsp(c0, 4, waited);
    if (v.nbeats == 0) chk("mis_latency", 64'(waited), 64'd0);
    @(negedge clk); #1;
    chk("rsp_pulse", {63'b0, rsp_valid}, 64'd0);
    chk("rdata_hold", rdata, v.e_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int waited;
    exp_t e;
    rst_n = 1'b0; req_valid = 1'b0; Mem_rw = 1'b0; size_type = 3'b0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    //      rw sz      addr        wdata                  rd0           rd1           nb gd ea           be       wd0           wd1           rdata                  err
    add_vec(1, 3'b010, 32'h1003, 64'h00000000000000A5, 32'h0,        32'h0,        1, 5, 32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h0,        64'h0,                 0);
    add_vec(0, 3'b110, 32'h1002, 64'h0,                32'h00800000, 32'h0,        1, 0, 32'h1000, 4'b0100, 32'h0,        32'h0,        64'hFFFFFFFFFFFFFF80, 0);
    add_vec(0, 3'b010, 32'h1002, 64'h0,                32'h00800000, 32'h0,        1, 1, 32'h1000, 4'b0100, 32'h0,        32'h0,        64'h0000000000000080, 0);
    add_vec(0, 3'b101, 32'h1002, 64'h0,                32'h80011234, 32'h0,        1, 2, 32'h1000, 4'b1100, 32'h0,        32'h0,        64'hFFFFFFFFFFFF8001, 0);
    add_vec(1, 3'b001, 32'h1000, 64'h000000000000BEEF, 32'h0,        32'h0,        1, 0, 32'h1000, 4'b0011, 32'hBEEFBEEF, 32'h0,        64'h0,                 0);
    add_vec(1, 3'b000, 32'h1004, 64'h00000000DEADBEEF, 32'h0,        32'h0,        1, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0,        64'h0,                 0);
    add_vec(0, 3'b100, 32'h1008, 64'h0,                32'h80000001, 32'h0,        1, 2, 32'h1008, 4'b1111, 32'h0,        32'h0,        64'hFFFFFFFF80000001, 0);
    add_vec(0, 3'b000, 32'h1008, 64'h0,                32'h80000001, 32'h0,        1, 0, 32'h1008, 4'b1111, 32'h0,        32'h0,        64'h0000000080000001, 0);
    add_vec(0, 3'b110, 32'h1000, 64'h0,                32'h1234567F, 32'h0,        1, 1, 32'h1000, 4'b0001, 32'h0,        32'h0,        64'h000000000000007F, 0);
    add_vec(0, 3'b001, 32'h3001, 64'h0,                32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        64'h0,                 1);
    add_vec(1, 3'b000, 32'h3002, 64'h0,                32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        64'h0,                 1);
    add_vec(0, 3'b011, 32'h2004, 64'h0,                32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        64'h0,                 1);
`ifdef MEM_DWORD_EN
    add_vec(0, 3'b011, 32'h2000, 64'h0,                32'h11223344, 32'h55667788, 2, 1, 32'h2000, 4'b1111, 32'h0,        32'h0,        64'h5566778811223344, 0);
    add_vec(1, 3'b011, 32'h2008, 64'h0123456789ABCDEF, 32'h0,        32'h0,        2, 2, 32'h2008, 4'b1111, 32'h89ABCDEF, 32'h01234567, 64'h0,                 0);
`else
    add_vec(0, 3'b011, 32'h2000, 64'h0,                32'h11223344, 32'h55667788, 0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        64'h0,                 1);
    add_vec(1, 3'b011, 32'h2008, 64'h0123456789ABCDEF, 32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        64'h0,                 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_rsp", {63'b0, rsp_valid}, 64'd0);
    chk("rst_err", {63'b0, misalign_err}, 64'd0);
    chk("rst_req", {63'b0, bus_req}, 64'd0);
    chk("rst_we", {63'b0, bus_we}, 64'd0);
    chk("rst_be", {60'b0, bus_be}, 64'd0);
    chk("rst_addr", {32'b0, bus_addr}, 64'd0);
    chk("rst_wdata", {32'b0, bus_wdata}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Grant and rvalid together in BEAT0: only the later rvalid supplies data.
    req_valid = 1'b1; Mem_rw = 1'b0; size_type = 3'b000; addr = 32'h5000;
    e.rdata = 64'h0000000012345678; e.err = 1'b0;
    exp_q.push_back(e);
    c0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("gnt_rv_no_early_rsp", {63'b0, rsp_valid}, 64'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    wait_rsp(c0, 4, waited);
    @(posedge clk); #1;

    // Reset while waiting for read data abandons the access.
    req_valid = 1'b1; Mem_rw = 1'b0; size_type = 3'b000; addr = 32'h4000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wrst_ready", {63'b0, req_ready}, 64'd1);
    chk("wrst_req", {63'b0, bus_req}, 64'd0);
    chk("wrst_rsp", {63'b0, rsp_valid}, 64'd0);
    chk("wrst_rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrst_no_rsp", {63'b0, rsp_valid}, 64'd0);
      chk("wrst_idle", {63'b0, req_ready}, 64'd1);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
